// File: rtl/hazard_ctrl_unit_if.sv
// Hazard-control bus between the decode/execute stages (master) and
// hazard_ctrl_unit (slave).
//   ID-side inputs : id_valid, id_rs1/2, id_uses_rs1/2, id_rd, id_reg_write, id_mem_read
//   EX/MEM inputs  : ex_branch_taken, dmem_busy
//   outputs        : forward_rs1/2 (0 NONE, 1 FROM_EX, 2 FROM_MEM), pc_en, if_id_en,
//                    if_id_flush, id_ex_flush, ex_mem_en, state_o
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  ex_branch_taken;
  logic                  dmem_busy;
  logic [1:0]            forward_rs1;
  logic [1:0]            forward_rs2;
  logic                  pc_en;
  logic                  if_id_en;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  ex_mem_en;
  logic [1:0]            state_o;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, ex_branch_taken, dmem_busy,
    input  forward_rs1, forward_rs2, pc_en, if_id_en, if_id_flush,
           id_ex_flush, ex_mem_en, state_o
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, ex_branch_taken, dmem_busy,
    output forward_rs1, forward_rs2, pc_en, if_id_en, if_id_flush,
           id_ex_flush, ex_mem_en, state_o
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Tracks rd of the instructions in EX/MEM/WB, produces registered operand
// forwarding selects for the instruction entering EX, and drives load-use
// stalls, taken-branch flushes and data-memory wait freezes.
//   clk, reset : core clock, synchronous active-high reset
//   hz         : hazard_ctrl_unit_if slave (ID fields, branch/busy in,
//                forward selects, stage enables/flushes, state_o out)
// forward encoding: 0 FORWARD_NONE, 1 FORWARD_FROM_EX, 2 FORWARD_FROM_MEM
// state_o encoding: 0 RUN, 1 LOAD_STALL, 2 FLUSH, 3 MEM_WAIT
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W         = 5,
  parameter int REGISTER_FILE_SIZE = 32,
  parameter int FLUSH_CYCLES       = 1
) (
  input logic               clk,
  input logic               reset,
  hazard_ctrl_unit_if.slave hz
);

  typedef enum logic [1:0] {
    FORWARD_NONE     = 2'd0,
    FORWARD_FROM_EX  = 2'd1,
    FORWARD_FROM_MEM = 2'd2
  } forward_type;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     reg_write;
    logic     mem_read;
  } stage_rec_t;

  localparam int NREG = 2 ** REG_ADDR_W;

  // Bit i set when index i is a real architectural register.
  function automatic logic [NREG-1:0] rf_mask_f();
    logic [NREG-1:0] m;
    m = '0;
    for (int i = 0; i < NREG; i++) m[i] = (i < REGISTER_FILE_SIZE);
    return m;
  endfunction

  localparam logic [NREG-1:0] RF_MASK    = rf_mask_f();
  localparam logic [1:0]      FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  function automatic logic rec_hit(stage_rec_t p, reg_idx_t rs, logic uses);
    return uses && p.valid && p.reg_write && (p.rd != '0) && RF_MASK[p.rd] && (p.rd == rs);
  endfunction

  // Youngest producer wins: EX is checked before MEM.
  function automatic forward_type fwd_sel(stage_rec_t ex, stage_rec_t mem,
                                          reg_idx_t rs, logic uses);
    if (rec_hit(ex, rs, uses))  return FORWARD_FROM_EX;
    if (rec_hit(mem, rs, uses)) return FORWARD_FROM_MEM;
    return FORWARD_NONE;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  stage_rec_t  ex_q, mem_q, wb_q, id_rec;
  forward_type fwd_rs1_q, fwd_rs1_d, fwd_rs2_q, fwd_rs2_d;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en;
  logic        load_use, advance;

  assign load_use = hz.id_valid && ex_q.mem_read &&
                    (rec_hit(ex_q, hz.id_rs1, hz.id_uses_rs1) ||
                     rec_hit(ex_q, hz.id_rs2, hz.id_uses_rs2));

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.dmem_busy) begin
          state_d = MEM_WAIT;
        end else if (hz.ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_cnt_d = FLUSH_LOAD;
          // The entry cycle is the first bubble; FLUSH only covers the rest.
          state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_d     = LOAD_STALL;
        end
      end
      LOAD_STALL: state_d = hz.dmem_busy ? MEM_WAIT : RUN;
      FLUSH: begin
        if (flush_cnt_q != 2'd0) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
        if (flush_cnt_q <= 2'd1) state_d = RUN;
      end
      MEM_WAIT: begin
        // Whole front end frozen; a branch seen here is re-presented by EX.
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        ex_mem_en = 1'b0;
        if (!hz.dmem_busy) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign advance = if_id_en && !id_ex_flush && ex_mem_en;

  always_comb begin
    id_rec = '0;
    if (hz.id_valid && if_id_en && !id_ex_flush)
      id_rec = '{valid: 1'b1, rd: hz.id_rd, reg_write: hz.id_reg_write, mem_read: hz.id_mem_read};
  end

  always_comb begin
    fwd_rs1_d = fwd_rs1_q;
    fwd_rs2_d = fwd_rs2_q;
    if (advance) begin
      fwd_rs1_d = fwd_sel(ex_q, mem_q, hz.id_rs1, hz.id_uses_rs1);
      fwd_rs2_d = fwd_sel(ex_q, mem_q, hz.id_rs2, hz.id_uses_rs2);
    end else if (ex_mem_en && id_ex_flush) begin
      fwd_rs1_d = FORWARD_NONE;
      fwd_rs2_d = FORWARD_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      flush_cnt_q <= 2'd0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_rs1_q   <= FORWARD_NONE;
      fwd_rs2_q   <= FORWARD_NONE;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      fwd_rs1_q   <= fwd_rs1_d;
      fwd_rs2_q   <= fwd_rs2_d;
      if (ex_mem_en) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= id_rec;
      end
    end
  end

  // Bubbles are loaded as all-zero records, so an invalid record never
  // carries stale rd/reg_write that could alias a later match.
  a_bubble_clean: assert property (@(posedge clk) disable iff (reset)
    (ex_q.valid || ex_q == '0) && (mem_q.valid || mem_q == '0) && (wb_q.valid || wb_q == '0));

  assign hz.forward_rs1 = fwd_rs1_q;
  assign hz.forward_rs2 = fwd_rs2_q;
  assign hz.pc_en       = pc_en;
  assign hz.if_id_en    = if_id_en;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.ex_mem_en   = ex_mem_en;
  assign hz.state_o     = state_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios followed by
// random stimulus, all compared against a cycle-level reference model.
module tb_hazard_ctrl_unit;
  localparam int RAW = 5;
  localparam int RFS = 28;
  localparam int FC  = 2;
  localparam int F_NONE = 0, F_EX = 1, F_MEM = 2;
  localparam int S_RUN = 0, S_LS = 1, S_FL = 2, S_MW = 3;

  logic clk, reset;
  int   n_tests = 0, n_fail = 0;

  hazard_ctrl_unit_if #(.REG_ADDR_W(RAW)) bus ();

  hazard_ctrl_unit #(.REG_ADDR_W(RAW), .REGISTER_FILE_SIZE(RFS), .FLUSH_CYCLES(FC)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit v; int rd; bit rw; bit mr; } rec_t;
  rec_t pipe[3];          // 0 = EX, 1 = MEM, 2 = WB
  bit   m_wait, m_stall;
  int   m_flush_left, m_f1, m_f2;

  function automatic bit hits(rec_t p, int rs, bit uses);
    return uses && p.v && p.rw && p.rd != 0 && p.rd < RFS && p.rd == rs;
  endfunction

  function automatic int pick(int rs, bit uses);
    if (hits(pipe[0], rs, uses)) return F_EX;
    if (hits(pipe[1], rs, uses)) return F_MEM;
    return F_NONE;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
    m_wait = 0; m_stall = 0; m_flush_left = 0; m_f1 = F_NONE; m_f2 = F_NONE;
  endtask

  // Called at the negedge: compare every output, then advance the model
  // across the coming posedge.
  task automatic cycle_check();
    bit e_pc = 1, e_ifid = 1, e_exmem = 1, e_iff = 0, e_idf = 0, lu;
    bit n_wait, n_stall = 0;
    int n_fl, e_state, rs1, rs2;
    rs1 = int'(bus.id_rs1); rs2 = int'(bus.id_rs2);
    n_wait = m_wait; n_fl = m_flush_left;
    e_state = m_wait ? S_MW : (m_flush_left > 0) ? S_FL : m_stall ? S_LS : S_RUN;
    lu = bus.id_valid && pipe[0].mr &&
         (hits(pipe[0], rs1, bus.id_uses_rs1) || hits(pipe[0], rs2, bus.id_uses_rs2));
    if (m_wait) begin
      e_pc = 0; e_ifid = 0; e_exmem = 0; n_wait = bus.dmem_busy;
    end else if (m_flush_left > 0) begin
      e_iff = 1; e_idf = 1; n_fl = m_flush_left - 1;
    end else if (m_stall || bus.dmem_busy) begin
      n_wait = bus.dmem_busy;
    end else if (bus.ex_branch_taken) begin
      e_iff = 1; e_idf = 1; n_fl = FC - 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_idf = 1; n_stall = 1;
    end
    chk("state",  bus.state_o,     e_state);
    chk("pc_en",  bus.pc_en,       e_pc);
    chk("ifid_en",bus.if_id_en,    e_ifid);
    chk("exm_en", bus.ex_mem_en,   e_exmem);
    chk("if_fl",  bus.if_id_flush, e_iff);
    chk("id_fl",  bus.id_ex_flush, e_idf);
    chk("fwd1",   bus.forward_rs1, m_f1);
    chk("fwd2",   bus.forward_rs2, m_f2);
    if (reset) begin
      model_reset();
    end else begin
      if (e_exmem) begin
        if (e_ifid && !e_idf) begin
          m_f1 = pick(rs1, bus.id_uses_rs1);
          m_f2 = pick(rs2, bus.id_uses_rs2);
        end else if (e_idf) begin
          m_f1 = F_NONE; m_f2 = F_NONE;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (bus.id_valid && e_ifid && !e_idf)
          pipe[0] = '{1, int'(bus.id_rd), bus.id_reg_write, bus.id_mem_read};
        else
          pipe[0] = '{0, 0, 0, 0};
      end
      m_wait = n_wait; m_stall = n_stall; m_flush_left = n_fl;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit rw, input bit mr);
    bus.id_valid = v; bus.id_rs1 = RAW'(rs1); bus.id_rs2 = RAW'(rs2);
    bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2;
    bus.id_rd = RAW'(rd); bus.id_reg_write = rw; bus.id_mem_read = mr;
  endtask

  function automatic int rnd_reg();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.ex_branch_taken = 1'b0;
    bus.dmem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // reset held 2 cycles during MEM_WAIT
    bus.dmem_busy = 1'b1;
    tick();
    tick();
    chk("mw_before_rst", bus.state_o, S_MW);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus.dmem_busy = 1'b0;
    #1;
    chk("rst_state", bus.state_o, S_RUN);
    chk("rst_pc",    bus.pc_en, 1);
    chk("rst_ifid",  bus.if_id_en, 1);
    chk("rst_exm",   bus.ex_mem_en, 1);
    chk("rst_fl",    {bus.if_id_flush, bus.id_ex_flush}, 0);
    chk("rst_fwd",   {bus.forward_rs1, bus.forward_rs2}, {2'(F_NONE), 2'(F_NONE)});

    // add x5 ; add x6,x5,x5
    set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();
    set_id(1, 5, 5, 1, 1, 6, 1, 0); tick();
    chk("b2b_fwd1", bus.forward_rs1, F_EX);
    chk("b2b_fwd2", bus.forward_rs2, F_EX);
    // add x5 ; add x9 ; add x6,x5,x5
    set_id(1, 1, 2, 1, 1, 5, 1, 0); tick();
    set_id(1, 1, 2, 1, 1, 9, 1, 0); tick();
    set_id(1, 5, 5, 1, 1, 6, 1, 0); tick();
    chk("gap_fwd1", bus.forward_rs1, F_MEM);
    chk("gap_fwd2", bus.forward_rs2, F_MEM);

    // lw x7 ; add x8,x7,x1
    set_id(1, 2, 0, 1, 0, 7, 1, 1); tick();
    set_id(1, 7, 1, 1, 1, 8, 1, 0); #1;
    chk("lu_pc",   bus.pc_en, 0);
    chk("lu_ifid", bus.if_id_en, 0);
    chk("lu_idfl", bus.id_ex_flush, 1);
    tick();
    chk("lu_state", bus.state_o, S_LS);
    tick();
    chk("lu_fwd1", bus.forward_rs1, F_MEM);
    chk("lu_fwd2", bus.forward_rs2, F_NONE);

    // lw x0 ; add reading x0 -> no stall, no forward
    set_id(1, 2, 0, 1, 0, 0, 1, 1); tick();
    set_id(1, 0, 0, 1, 1, 8, 1, 0); #1;
    chk("x0_pc", bus.pc_en, 1);
    tick();
    chk("x0_fwd", {bus.forward_rs1, bus.forward_rs2}, 0);

    // lw x30 (beyond register file) ; consumer of x30
    set_id(1, 2, 0, 1, 0, 30, 1, 1); tick();
    set_id(1, 30, 30, 1, 1, 8, 1, 0); #1;
    chk("rf_pc", bus.pc_en, 1);
    tick();
    chk("rf_fwd", {bus.forward_rs1, bus.forward_rs2}, 0);

    // taken branch, FLUSH_CYCLES = 2
    set_id(1, 1, 2, 1, 1, 3, 1, 0);
    bus.ex_branch_taken = 1'b1; #1;
    chk("br_fl0", {bus.if_id_flush, bus.id_ex_flush}, 2'b11);
    tick();
    bus.ex_branch_taken = 1'b0; #1;
    chk("br_state", bus.state_o, S_FL);
    chk("br_fl1", {bus.if_id_flush, bus.id_ex_flush}, 2'b11);
    tick();
    chk("br_done", bus.state_o, S_RUN);
    chk("br_fl2", {bus.if_id_flush, bus.id_ex_flush}, 0);

    // dmem_busy 3 cycles with a load-use and a branch pending
    set_id(1, 2, 0, 1, 0, 3, 1, 1);
    bus.dmem_busy = 1'b1;
    tick();
    set_id(1, 3, 1, 1, 1, 4, 1, 0);
    bus.ex_branch_taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.dmem_busy = 1'b0;
      #1;
      chk("mw_exm", bus.ex_mem_en, 0);
      tick();
    end
    #1;
    chk("mw_after_fl", bus.if_id_flush, 1);
    chk("mw_after_pc", bus.pc_en, 1);
    tick();
    chk("mw_after_st", bus.state_o, S_FL);
    bus.ex_branch_taken = 1'b0;
    tick();

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.dmem_busy = ($urandom_range(0, 7) == 0);
      bus.ex_branch_taken = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 7) != 0, rnd_reg(), rnd_reg(), $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1, rnd_reg(), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Pipeline sequencing controller for the 5-stage RV32I core. It tracks destination registers of in-flight instructions in EX, MEM and WB. For the instruction entering EX it drives registered forwarding selects (forward_type) for rs1/rs2, and it generates load-use stalls, branch flushes and data-memory wait freezes. It sits beside the decode/execute stages and feeds the operand forwarding muxes, the pipeline-register enables and the PC enable.

Parameters:
REG_ADDR_W, 5, register index width
REGISTER_FILE_SIZE, 32, number of architectural registers; indices >= this never match
FLUSH_CYCLES, 1, bubbles inserted into ID/EX after a taken branch (1..3)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_ADDR_W  ID source register 1
id_rs2  in  REG_ADDR_W  ID source register 2
id_uses_rs1  in  1  ID instruction reads rs1 (R/I/S/B encodings)
id_uses_rs2  in  1  ID instruction reads rs2 (R/S/B encodings)
id_rd  in  REG_ADDR_W  ID destination
id_reg_write  in  1  ID instruction writes rd
id_mem_read  in  1  ID instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
dmem_busy  in  1  data memory not ready; MEM cannot complete
forward_rs1  out  forward_type  select for the EX-stage rs1 operand
forward_rs2  out  forward_type  select for the EX-stage rs2 operand
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  load bubble (NOP, reg_write=0) into ID/EX
ex_mem_en  out  1  EX/MEM and MEM/WB enable
state_o  out  2  FSM state, for debug/SVA

Behaviour:
- Reset:
  - FSM enters RUN.
  - All shadow stage records (valid, rd, reg_write, mem_read for EX/MEM/WB) are cleared.
  - forward_rs1/2 = FORWARD_NONE (register-file value).
  - pc_en = if_id_en = ex_mem_en = 1; if_id_flush = id_ex_flush = 0.
  - Reset mid-stall or mid-flush aborts the operation the same way.
- Matching:
  - A producer matches a source only when valid && reg_write && rd != 0 && rd < REGISTER_FILE_SIZE && rd == rs && uses_rs.
- Forwarding:
  - Forwarding outputs are registered. On every cycle where ID advances into EX (if_id_en && !id_ex_flush && !freeze), the ID sources are compared against the EX and MEM shadow records.
  - Match against EX (the producer that will sit in EX/MEM next cycle) latches FORWARD_FROM_EX.
  - Otherwise, a match against MEM latches FORWARD_FROM_MEM.
  - Otherwise the output latches FORWARD_NONE.
  - The youngest producer wins.
  - When a bubble is inserted, the outputs latch FORWARD_NONE.
  - During a freeze, the outputs hold.
- Shadow pipeline:
  - On advance: WB <= MEM, MEM <= EX, EX <= ID fields.
  - EX receives valid = 0 on a bubble or flush.
  - During a freeze, nothing shifts.
- FSM states: RUN, LOAD_STALL, FLUSH, MEM_WAIT.
- RUN:
  - dmem_busy -> MEM_WAIT.
  - else ex_branch_taken -> FLUSH. Same cycle: if_id_flush = id_ex_flush = 1; counter loaded with FLUSH_CYCLES-1.
  - else load-use (EX record is a valid load matching an ID source, and id_valid) -> LOAD_STALL. Same cycle: pc_en = if_id_en = 0, id_ex_flush = 1.
- LOAD_STALL:
  - Lasts exactly one cycle and returns to RUN.
  - The load is now in MEM, so the dependent instruction later gets FORWARD_FROM_MEM.
  - dmem_busy takes precedence -> MEM_WAIT.
- FLUSH:
  - id_ex_flush = 1 and if_id_flush = 1 while the counter is > 0; the counter decrements each cycle.
  - Returns to RUN at 0.
  - With FLUSH_CYCLES=1, FLUSH is never held beyond the entry cycle.
- MEM_WAIT:
  - pc_en = if_id_en = ex_mem_en = 0; no flush asserted.
  - Stays while dmem_busy; returns to RUN the cycle after dmem_busy drops.
  - A branch_taken sampled during the freeze is ignored (EX is frozen and re-presents it).
- Priority on the same cycle: dmem_busy > ex_branch_taken > load-use.
  - A taken branch coinciding with a load-use flushes; it does not stall.
- Outputs are combinational from state plus inputs, except forward_rs1/2 and state_o, which are registered.

Test Plan:
- Reset held 2 cycles during MEM_WAIT -> state_o=RUN, pc_en=if_id_en=ex_mem_en=1, forward_rs1=forward_rs2=FORWARD_NONE, flushes 0.
- add x5 then add x6,x5,x5 back-to-back -> next cycle forward_rs1=forward_rs2=FORWARD_FROM_EX; with one independent instruction between them -> FORWARD_FROM_MEM.
- lw x7 followed by add x8,x7,x1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1, state LOAD_STALL; then forward_rs1=FORWARD_FROM_MEM, forward_rs2=FORWARD_NONE.
- Producer rd=x0 with consumer reading x0 -> forward stays FORWARD_NONE and no stall, even when the producer is a load.
- ex_branch_taken=1 with FLUSH_CYCLES=2 -> if_id_flush=id_ex_flush=1 for 2 consecutive cycles, then RUN.
- dmem_busy held 3 cycles while a load-use and a branch are pending -> 3 cycles of ex_mem_en=0 with forwards held; then the branch flush occurs and the load-use stall is suppressed.
